// File: rtl/y_writeback.sv
// rtl/y_writeback.sv - Y SRAM write-back stage with read-modify-write and one-word merge cache
module y_writeback #(
  parameter int NUM_ROWS = 256,
  parameter int LOG2_WPR = 3,
  parameter int ADDR_W   = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [47:0]       in_yVal,
  input  logic [15:0]       in_row,
  input  logic [15:0]       in_col,
  input  logic              in_lastFlag,
  output logic              sram_rdEn,
  output logic [ADDR_W-1:0] sram_rdAddr,
  input  logic [255:0]      sram_rdData,
  output logic              sram_wrEn,
  output logic [ADDR_W-1:0] sram_wrAddr,
  output logic [255:0]      sram_wrData,
  output logic              wb_busy,
  output logic              wb_done,
  output logic              wb_errRange
);

  // Comparison limits widened by one bit so the 16-bit row/col compare cleanly.
  localparam logic [16:0] ROW_LIM = 17'(NUM_ROWS);
  localparam logic [16:0] COL_LIM = 17'(4 << LOG2_WPR);

  typedef enum logic [1:0] {IDLE, RD, WAIT, WR} state_e;

  typedef struct packed {
    logic [47:0] val;
    logic [15:0] row;
    logic [15:0] col;
  } entry_t;

  state_e            state_q, state_d;
  entry_t            fifo_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q, count_d;
  logic              in_ready_q;
  logic              cache_vld_q;
  logic [ADDR_W-1:0] cache_addr_q;
  logic [255:0]      cache_data_q;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [255:0]      wr_data_q;
  logic              done_q, done_d, done_arm_q;

  entry_t            head;
  logic              head_vld, in_range, hit;
  logic              push, pop, load_rd, load_wr;
  logic [ADDR_W-1:0] head_addr;
  logic [255:0]      merge_base, merged;

  assign push      = in_valid & in_ready_q;
  assign head      = fifo_q[rd_ptr_q];
  assign head_vld  = (count_q != 2'd0);
  assign in_range  = ({1'b0, head.row} < ROW_LIM) && ({1'b0, head.col} < COL_LIM);
  assign head_addr = (ADDR_W'(head.row) << LOG2_WPR) + ADDR_W'(head.col[LOG2_WPR+1:2]);
  assign hit       = cache_vld_q && (cache_addr_q == head_addr);

  // Insert the head value into its 64-bit slot of either the fresh SRAM word or the cached word.
  always_comb begin
    merge_base = (state_q == WAIT) ? sram_rdData : cache_data_q;
    merged     = merge_base;
    for (int s = 0; s < 4; s++) begin
      if (head.col[1:0] == 2'(s)) merged[64*s +: 64] = {16'h0, head.val};
    end
  end

  // Next-state and strobe decode; out-of-range heads are dropped straight from IDLE.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    load_rd     = 1'b0;
    load_wr     = 1'b0;
    sram_rdEn   = 1'b0;
    sram_wrEn   = 1'b0;
    wb_errRange = 1'b0;
    case (state_q)
      IDLE: begin
        if (head_vld) begin
          if (!in_range) begin
            pop         = 1'b1;
            wb_errRange = 1'b1;
          end else if (hit) begin
            state_d = WR;
            load_wr = 1'b1;
          end else begin
            state_d = RD;
            load_rd = 1'b1;
          end
        end
      end
      RD: begin
        sram_rdEn = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        load_wr = 1'b1;
        state_d = WR;
      end
      WR: begin
        sram_wrEn = 1'b1;
        pop       = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO occupancy and the done condition as seen after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    done_d = done_arm_q & in_lastFlag & (state_d == IDLE) & (count_d == 2'd0);
  end

  // Control state, cache, address/data holding registers and done pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      in_ready_q   <= 1'b0;
      cache_vld_q  <= 1'b0;
      cache_addr_q <= '0;
      cache_data_q <= '0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      done_q       <= 1'b0;
      done_arm_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      in_ready_q <= (count_d != 2'd2);
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      if (load_rd) rd_addr_q <= head_addr;
      if (load_wr) begin
        wr_addr_q <= head_addr;
        wr_data_q <= merged;
      end
      if (state_q == WR) begin
        cache_vld_q  <= 1'b1;
        cache_addr_q <= wr_addr_q;
        cache_data_q <= wr_data_q;
      end
      done_q <= done_d;
      if (!in_lastFlag)  done_arm_q <= 1'b1;
      else if (done_d)   done_arm_q <= 1'b0;
    end
  end

  // FIFO payload storage needs no reset; occupancy guards every read.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= '{val: in_yVal, row: in_row, col: in_col};
  end

  assign in_ready    = in_ready_q;
  assign sram_rdAddr = rd_addr_q;
  assign sram_wrAddr = wr_addr_q;
  assign sram_wrData = wr_data_q;
  assign wb_busy     = head_vld | (state_q != IDLE);
  assign wb_done     = done_q;

endmodule

// File: tb/tb_y_writeback.sv
// tb/tb_y_writeback.sv - scoreboard testbench for y_writeback
module tb_y_writeback;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [47:0]  in_yVal;
  logic [15:0]  in_row;
  logic [15:0]  in_col;
  logic         in_lastFlag;
  logic         sram_rdEn;
  logic [10:0]  sram_rdAddr;
  logic [255:0] sram_rdData;
  logic         sram_wrEn;
  logic [10:0]  sram_wrAddr;
  logic [255:0] sram_wrData;
  logic         wb_busy;
  logic         wb_done;
  logic         wb_errRange;

  always #5 clock = ~clock;

  y_writeback dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_yVal     (in_yVal),
    .in_row      (in_row),
    .in_col      (in_col),
    .in_lastFlag (in_lastFlag),
    .sram_rdEn   (sram_rdEn),
    .sram_rdAddr (sram_rdAddr),
    .sram_rdData (sram_rdData),
    .sram_wrEn   (sram_wrEn),
    .sram_wrAddr (sram_wrAddr),
    .sram_wrData (sram_wrData),
    .wb_busy     (wb_busy),
    .wb_done     (wb_done),
    .wb_errRange (wb_errRange)
  );

  typedef struct {
    logic [10:0]  addr;
    logic [255:0] data;
  } wr_exp_t;

  wr_exp_t      sb[$];
  logic [255:0] mem     [2048];
  logic [255:0] ref_mem [2048];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, err_cnt = 0, done_cnt = 0, stall_cnt = 0;
  int last_wr_cyc = 0, last_done_cyc = 0, acc_cyc = 0;
  logic [10:0]  last_rd_addr = '0;
  logic [255:0] last_wr_data = '0;
  logic         err_prev = 1'b0;

  localparam logic [255:0] T1_DATA = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                      64'h0000_1234_56AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF};
  localparam logic [255:0] T2_DATA = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0100_0002,
                                      64'h0000_1234_56AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] init_word(input int a);
    if (a == 17) return '1;
    return {8{32'(a) * 32'h9E37_79B1}};
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // SRAM model: one-cycle read latency
  always @(posedge clock) begin
    if (sram_rdEn) sram_rdData <= mem[sram_rdAddr];
    if (sram_wrEn) mem[sram_wrAddr] <= sram_wrData;
  end

  // Output monitor and scoreboard check, sampled on the falling edge
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (sram_rdEn) begin
        rd_cnt++;
        last_rd_addr = sram_rdAddr;
      end
      if (sram_wrEn) begin
        wr_cnt++;
        last_wr_cyc  = cyc;
        last_wr_data = sram_wrData;
        chk("sb_has_entry_at_wr", 256'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          wr_exp_t e;
          e = sb.pop_front();
          chk("wr_addr", sram_wrAddr, e.addr);
          chk("wr_data", sram_wrData, e.data);
        end
      end
      if (wb_errRange) begin
        err_cnt++;
        chk("err_pulse_1cyc", err_prev, 0);
      end
      err_prev = wb_errRange;
      if (wb_done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  // Drive one entry (caller sits just after a rising edge); optionally record its expected write.
  task automatic send(input logic [15:0] r, input logic [15:0] c, input logic [47:0] v,
                      input bit exp_wr, input bit last);
    bit acc = 1'b0;
    in_row = r; in_col = c; in_yVal = v; in_valid = 1'b1;
    if (last) in_lastFlag = 1'b1;
    if (exp_wr) begin
      int a = int'(r) * 8 + int'(c) / 4;
      int s = int'(c) % 4;
      wr_exp_t e;
      e.addr = 11'(a);
      e.data = ref_mem[a];
      e.data[64*s +: 64] = {16'h0, v};
      ref_mem[a] = e.data;
      sb.push_back(e);
    end
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      acc = in_ready;
      acc_cyc = cyc;
      if (!acc) stall_cnt++;
      @(posedge clock);
      #1;
      if (acc) break;
    end
    chk("send_accepted", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_wr(input int target);
    for (int n = 0; n < 100 && wr_cnt < target; n++) @(negedge clock);
    chk("write_arrived", 256'(wr_cnt >= target), 1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && wb_busy; n++) @(negedge clock);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int r0, w0, e0, d0, s0, a0;
    reset = 1'b0; in_valid = 1'b0; in_yVal = '0; in_row = '0; in_col = '0; in_lastFlag = 1'b0;
    for (int a = 0; a < 2048; a++) begin
      mem[a]     = init_word(a);
      ref_mem[a] = init_word(a);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rdEn", sram_rdEn, 0);
    chk("rst_wrEn", sram_wrEn, 0);
    chk("rst_rdAddr", sram_rdAddr, 0);
    chk("rst_wrAddr", sram_wrAddr, 0);
    chk("rst_wrData", sram_wrData, 0);
    chk("rst_busy", wb_busy, 0);
    chk("rst_done_err", {wb_done, wb_errRange}, 0);
    sync();
    reset = 1'b1;
    @(negedge clock);
    chk("ready_before_first_clk", in_ready, 0);
    @(negedge clock);
    chk("ready_after_first_clk", in_ready, 1);

    // Miss path
    sync();
    r0 = rd_cnt; w0 = wr_cnt;
    send(16'd2, 16'd5, 48'h123456_ABCDEF, 1, 0);
    a0 = acc_cyc;
    wait_wr(w0 + 1);
    chk("miss_rd_addr", last_rd_addr, 11'h011);
    chk("miss_rd_count", rd_cnt - r0, 1);
    chk("miss_latency", last_wr_cyc - a0, 4);
    chk("miss_data", last_wr_data, T1_DATA);
    wait_idle();

    // Hit merge into the cached word
    sync();
    r0 = rd_cnt; w0 = wr_cnt;
    send(16'd2, 16'd6, 48'h000001_000002, 1, 0);
    a0 = acc_cyc;
    wait_wr(w0 + 1);
    chk("hit_no_read", rd_cnt - r0, 0);
    chk("hit_latency", last_wr_cyc - a0, 2);
    chk("hit_data", last_wr_data, T2_DATA);
    wait_idle();

    // Out-of-range row, then column, then a good entry
    r0 = rd_cnt; w0 = wr_cnt; e0 = err_cnt;
    sync();
    send(16'd256, 16'd0, 48'h111111_111111, 0, 0);
    wait_idle();
    chk("range_row_err", err_cnt - e0, 1);
    sync();
    send(16'd3, 16'd32, 48'h222222_222222, 0, 0);
    wait_idle();
    chk("range_col_err", err_cnt - e0, 2);
    chk("range_no_rd", rd_cnt - r0, 0);
    chk("range_no_wr", wr_cnt - w0, 0);
    sync();
    send(16'd3, 16'd31, 48'h333333_333333, 1, 0);
    wait_wr(w0 + 1);
    wait_idle();

    // Back-pressure: five back-to-back entries to distinct words
    w0 = wr_cnt; s0 = stall_cnt;
    sync();
    for (int i = 0; i < 5; i++)
      send(16'(10 + i), 16'(i * 4), {24'(i + 1), 24'h0A0B0C ^ 24'(i)}, 1, 0);
    wait_wr(w0 + 5);
    chk("bp_stalled", 256'(stall_cnt > s0), 1);
    chk("bp_wr_count", wr_cnt - w0, 5);
    chk("bp_sb_drained", sb.size(), 0);
    wait_idle();

    // Done pulse on the last entry
    d0 = done_cnt; w0 = wr_cnt;
    sync();
    send(16'd20, 16'd1, 48'hDEAD00_BEEF00, 1, 1);
    wait_wr(w0 + 1);
    repeat (10) @(negedge clock);
    chk("done_single_pulse", done_cnt - d0, 1);
    chk("done_timing", last_done_cyc - last_wr_cyc, 1);
    sync();
    in_lastFlag = 1'b0;
    wait_idle();

    // Reset during WAIT: write word 320, then abandon a miss to 328, then revisit 320
    w0 = wr_cnt;
    sync();
    send(16'd40, 16'd0, 48'h404040_404040, 1, 0);
    wait_wr(w0 + 1);
    wait_idle();
    r0 = rd_cnt;
    sync();
    send(16'd41, 16'd0, 48'h414141_414141, 0, 0);
    for (int n = 0; n < 20 && rd_cnt == r0; n++) @(negedge clock);
    chk("rstmid_reached_rd", rd_cnt - r0, 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("rstmid_rdEn", sram_rdEn, 0);
    chk("rstmid_wrEn", sram_wrEn, 0);
    chk("rstmid_addrs", {sram_rdAddr, sram_wrAddr}, 0);
    chk("rstmid_wrData", sram_wrData, 0);
    chk("rstmid_flags", {in_ready, wb_busy, wb_done, wb_errRange}, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    w0 = wr_cnt;
    repeat (10) @(negedge clock);
    chk("rstmid_no_wr", wr_cnt - w0, 0);
    r0 = rd_cnt;
    sync();
    send(16'd40, 16'd1, 48'h505050_505050, 1, 0);
    wait_wr(w0 + 1);
    chk("rstmid_cache_invalid_miss", rd_cnt - r0, 1);
    wait_idle();

    chk("sb_empty_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
